ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 receive FIFO and consumes its byte/ready/nextdata_n handshake.
- Assembles PS/2 set-2 scancode bytes (E0 extended prefix, F0 break prefix, E1 pause sequence) into single key events.
- Tracks shift and held-key state, suppresses typematic repeats from the press counter, and emits ASCII for printable keys.
- Its output feeds the keyboard MMIO/display logic.

Parameters:
- PAUSE_SKIP, 7, number of bytes discarded after an E1 prefix.
- CNT_W, 8, width of the press counter.

Ports:
- clk  input  1  system clock
- clrn  input  1  asynchronous, active-high reset
- kbd_data  input  8  byte at FIFO head
- kbd_ready  input  1  FIFO non-empty
- kbd_nextdata_n  output  1  active-low pop strobe to FIFO
- key_valid  output  1  one-cycle event pulse
- key_code  output  8  scancode of event (prefixes stripped)
- key_ext  output  1  event carried E0 prefix
- key_break  output  1  event is a release
- key_repeat  output  1  make matching the currently held key
- key_ascii  output  8  ASCII of event, 0 if none
- shift_down  output  1  either shift held
- key_held  output  1  a non-shift key is held
- press_count  output  CNT_W  count of non-repeat make events

Behaviour:
- Reset (async, clrn=1) forces:
  - kbd_nextdata_n=1; key_valid=0; key_code=0; key_ext=0; key_break=0; key_repeat=0; key_ascii=0; shift_down=0; key_held=0; press_count=0.
  - All internal flags cleared, held_code=0, skip counter=0, FSM to IDLE.
- Reset mid-handshake drops any in-flight byte; no partial event is emitted after reset release.
- FSM IDLE/ACK/WAIT:
  - IDLE with kbd_ready=1: latch kbd_data into byte_r, drive kbd_nextdata_n<=0, go to ACK.
  - ACK: kbd_nextdata_n<=1, decode byte_r, go to WAIT.
  - WAIT: key_valid<=0, go to IDLE. kbd_ready is ignored in WAIT so the FIFO's ready has settled.
- kbd_nextdata_n is low for exactly one cycle per byte. Throughput is 1 byte per 3 cycles.
- Latency: key_valid is high during the cycle after the ACK edge, i.e. 2 edges after ready is sampled.
- Decode priority in ACK:
  - Skip counter nonzero: decrement, no other effect.
  - E1: skip counter<=PAUSE_SKIP, clear prefix flags.
  - E0: ext_f<=1.
  - F0: brk_f<=1.
  - AA, FA, EE, FE, 00, FF: consume silently, clear prefix flags.
  - Any other byte is a key:
    - Emit key_valid=1 with key_code=byte, key_ext=ext_f, key_break=brk_f; then clear ext_f and brk_f.
- Shift keys (12, 59, non-extended):
  - Make sets the corresponding left/right bit; break clears it. shift_down = OR of the two bits.
  - Shift events are emitted but never touch held_code, key_held or press_count.
- Non-shift make:
  - If key_held=1 and {ext,code} equals held: key_repeat=1, press_count unchanged.
  - Otherwise: key_repeat=0, press_count+=1 (wraps modulo 2^CNT_W), held<= {ext,code}, key_held<=1.
- Non-shift break matching held: key_held<=0. A break not matching held leaves key_held unchanged. Breaks always have key_repeat=0.
- key_ascii (make and break alike; 0 if key_ext=1):
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z. Uppercase (0x41–0x5A) when shift_down (value before this byte).
  - Digits: 16..1,1E..2,26..3,25..4,2E..5,36..6,3D..7,3E..8,46..9,45..0.
  - 29→0x20, 5A→0x0D, 66→0x08.
  - All other codes → 0.
- key_code/key_ext/key_break/key_repeat/key_ascii hold their last values between events.
- A prefix followed by reset is lost. Consecutive E0 E0 is the same as a single E0. F0 before E0 (F0 E0 xx) sets both flags.

Optional Feature:
- CAPS_LOCK_EN.
- Defined:
  - Adds output caps_lock (1 bit, reset 0).
  - A non-repeat make of 58 toggles caps_lock.
  - Letter case = shift_down XOR caps_lock.
  - 58 is still treated as a normal held key.
- Undefined: no caps_lock port; 58 decodes as an ordinary key with ascii 0.

Test Plan:
- FIFO presents 1C, then F0 1C → one pulse with code=1C, break=0, ascii=0x61, press_count=1. Then one pulse with break=1, key_held=0. kbd_nextdata_n is low for exactly 3 single cycles.
- 12, 1C, F0 1C, F0 12 → second event ascii=0x41. shift_down high between event 1 and event 4. press_count=1.
- 1C, 1C, 1C (typematic) → three pulses with key_repeat=0,1,1. press_count=1.
- E0 75, E0 F0 75 → code=75, ext=1, ascii=0 on both; break=0 then 1.
- E1 14 77 E1 F0 14 F0 77 then 29 → no events for the first 8 bytes; then code=29, ascii=0x20.
- Assert clrn while in ACK after F0 is latched, then feed 1C → kbd_nextdata_n=1 immediately. The 1C emits as a make (break=0), press_count=1.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode assembler: turns FIFO bytes into key events with shift/held/repeat tracking and ASCII.
// Optional CAPS_LOCK_EN adds a caps_lock output toggled by the caps key.
module ps2_scancode_decoder #(
  parameter int PAUSE_SKIP = 7,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  output logic             kbd_nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_repeat,
  output logic [7:0]       key_ascii,
  output logic             shift_down,
  output logic             key_held,
  output logic [CNT_W-1:0] press_count
`ifdef CAPS_LOCK_EN
  , output logic           caps_lock
`endif
);

  localparam int SKIP_W = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_e;

  state_e            state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic              nd_q, nd_d;
  logic              valid_q, valid_d;
  logic [7:0]        kcode_q, kcode_d;
  logic              kext_q, kext_d;
  logic              kbrk_q, kbrk_d;
  logic              krep_q, krep_d;
  logic [7:0]        kascii_q, kascii_d;
  logic              ext_f_q, ext_f_d;
  logic              brk_f_q, brk_f_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              lsh_q, lsh_d;
  logic              rsh_q, rsh_d;
  logic [8:0]        held_q, held_d;
  logic              held_v_q, held_v_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [8:0]        key_id;
  logic              upper;
`ifdef CAPS_LOCK_EN
  logic              caps_q, caps_d;
`endif

  function automatic logic [7:0] ascii_of(input logic [7:0] c, input logic up);
    logic [7:0] a;
    a = '0;
    case (c)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33; 8'h25: a = 8'h34;
      8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37; 8'h3E: a = 8'h38;
      8'h46: a = 8'h39; 8'h45: a = 8'h30;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
      default: a = '0;
    endcase
    if (up && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
    return a;
  endfunction

  assign key_id = {ext_f_q, byte_q};

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    nd_d     = 1'b1;
    valid_d  = 1'b0;
    kcode_d  = kcode_q;
    kext_d   = kext_q;
    kbrk_d   = kbrk_q;
    krep_d   = krep_q;
    kascii_d = kascii_q;
    ext_f_d  = ext_f_q;
    brk_f_d  = brk_f_q;
    skip_d   = skip_q;
    lsh_d    = lsh_q;
    rsh_d    = rsh_q;
    held_d   = held_q;
    held_v_d = held_v_q;
    cnt_d    = cnt_q;
`ifdef CAPS_LOCK_EN
    caps_d   = caps_q;
    upper    = (lsh_q | rsh_q) ^ caps_q;
`else
    upper    = lsh_q | rsh_q;
`endif
    case (state_q)
      IDLE: if (kbd_ready) begin
        byte_d  = kbd_data;
        nd_d    = 1'b0;
        state_d = ACK;
      end
      ACK: begin
        state_d = WAIT;
        if (skip_q != '0) begin
          skip_d = skip_q - SKIP_W'(1);
        end else begin
          case (byte_q)
            8'hE1: begin
              skip_d  = SKIP_W'(PAUSE_SKIP);
              ext_f_d = 1'b0;
              brk_f_d = 1'b0;
            end
            8'hE0: ext_f_d = 1'b1;
            8'hF0: brk_f_d = 1'b1;
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
              ext_f_d = 1'b0;
              brk_f_d = 1'b0;
            end
            default: begin
              valid_d  = 1'b1;
              kcode_d  = byte_q;
              kext_d   = ext_f_q;
              kbrk_d   = brk_f_q;
              krep_d   = 1'b0;
              kascii_d = ext_f_q ? 8'h00 : ascii_of(byte_q, upper);
              ext_f_d  = 1'b0;
              brk_f_d  = 1'b0;
              // Shift keys only move the shift bits; everything else drives held/repeat/count.
              if (key_id == 9'h012) begin
                lsh_d = ~brk_f_q;
              end else if (key_id == 9'h059) begin
                rsh_d = ~brk_f_q;
              end else if (!brk_f_q) begin
                if (held_v_q && (key_id == held_q)) begin
                  krep_d = 1'b1;
                end else begin
                  cnt_d    = cnt_q + CNT_W'(1);
                  held_d   = key_id;
                  held_v_d = 1'b1;
`ifdef CAPS_LOCK_EN
                  if (key_id == 9'h058) caps_d = ~caps_q;
`endif
                end
              end else if (key_id == held_q) begin
                held_v_d = 1'b0;
              end
            end
          endcase
        end
      end
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_q  <= IDLE;
      byte_q   <= '0;
      nd_q     <= 1'b1;
      valid_q  <= 1'b0;
      kcode_q  <= '0;
      kext_q   <= 1'b0;
      kbrk_q   <= 1'b0;
      krep_q   <= 1'b0;
      kascii_q <= '0;
      ext_f_q  <= 1'b0;
      brk_f_q  <= 1'b0;
      skip_q   <= '0;
      lsh_q    <= 1'b0;
      rsh_q    <= 1'b0;
      held_q   <= '0;
      held_v_q <= 1'b0;
      cnt_q    <= '0;
`ifdef CAPS_LOCK_EN
      caps_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      nd_q     <= nd_d;
      valid_q  <= valid_d;
      kcode_q  <= kcode_d;
      kext_q   <= kext_d;
      kbrk_q   <= kbrk_d;
      krep_q   <= krep_d;
      kascii_q <= kascii_d;
      ext_f_q  <= ext_f_d;
      brk_f_q  <= brk_f_d;
      skip_q   <= skip_d;
      lsh_q    <= lsh_d;
      rsh_q    <= rsh_d;
      held_q   <= held_d;
      held_v_q <= held_v_d;
      cnt_q    <= cnt_d;
`ifdef CAPS_LOCK_EN
      caps_q   <= caps_d;
`endif
    end
  end

  assign kbd_nextdata_n = nd_q;
  assign key_valid      = valid_q;
  assign key_code       = kcode_q;
  assign key_ext        = kext_q;
  assign key_break      = kbrk_q;
  assign key_repeat     = krep_q;
  assign key_ascii      = kascii_q;
  assign shift_down     = lsh_q | rsh_q;
  assign key_held       = held_v_q;
  assign press_count    = cnt_q;
`ifdef CAPS_LOCK_EN
  assign caps_lock      = caps_q;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench: a byte-stream reference model predicts events; a monitor pops and compares on key_valid.
module tb_ps2_scancode_decoder;
  localparam int PAUSE_SKIP = 7;
  localparam int CNT_W      = 8;

  logic             clk = 1'b0;
  logic             clrn = 1'b1;
  logic [7:0]       kbd_data = 8'h00;
  logic             kbd_ready = 1'b0;
  logic             kbd_nextdata_n, key_valid, key_ext, key_break, key_repeat, shift_down, key_held;
  logic [7:0]       key_code, key_ascii;
  logic [CNT_W-1:0] press_count;
`ifdef CAPS_LOCK_EN
  logic             caps_lock;
`endif

  ps2_scancode_decoder #(.PAUSE_SKIP(PAUSE_SKIP), .CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_nextdata_n(kbd_nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_break(key_break), .key_repeat(key_repeat),
    .key_ascii(key_ascii), .shift_down(shift_down), .key_held(key_held),
    .press_count(press_count)
`ifdef CAPS_LOCK_EN
    , .caps_lock(caps_lock)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code; logic ext, brk, rep; logic [7:0] ascii;
    logic shift, held; logic [CNT_W-1:0] cnt; logic caps;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fifo[$];
  int n_total = 0, n_pass = 0, n_lows = 0, n_sent = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] amap[256];
  int  m_skip, m_held_key, m_cnt;
  bit  m_ext, m_brk, m_lsh, m_rsh, m_held, m_caps;

  task automatic model_reset();
    m_skip = 0; m_held_key = 0; m_cnt = 0;
    m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_held = 0; m_caps = 0;
  endtask

  task automatic build_map();
    string letters = "abcdefghijklmnopqrstuvwxyz";
    string digits  = "1234567890";
    logic [7:0] lc[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                           8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] dc[10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
    for (int i = 0; i < 256; i++) amap[i] = 8'h00;
    for (int i = 0; i < 26; i++) amap[lc[i]] = letters[i];
    for (int i = 0; i < 10; i++) amap[dc[i]] = digits[i];
    amap[8'h29] = 8'h20; amap[8'h5A] = 8'h0D; amap[8'h66] = 8'h08;
  endtask

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    int  key;
    bit  up;
    if (m_skip > 0) begin m_skip--; return; end
    if (b == 8'hE1) begin m_skip = PAUSE_SKIP; m_ext = 0; m_brk = 0; return; end
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin m_ext = 0; m_brk = 0; return; end
    key = (m_ext ? 256 : 0) + int'(b);
`ifdef CAPS_LOCK_EN
    up = (m_lsh || m_rsh) ^ m_caps;
`else
    up = m_lsh || m_rsh;
`endif
    e.code = b; e.ext = m_ext; e.brk = m_brk; e.rep = 0;
    e.ascii = m_ext ? 8'h00 : amap[b];
    if (up && e.ascii >= 8'h61 && e.ascii <= 8'h7A) e.ascii = e.ascii - 8'h20;
    if (key == 'h12) m_lsh = !m_brk;
    else if (key == 'h59) m_rsh = !m_brk;
    else if (!m_brk) begin
      if (m_held && key == m_held_key) e.rep = 1;
      else begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_held_key = key; m_held = 1;
`ifdef CAPS_LOCK_EN
        if (key == 'h58) m_caps = !m_caps;
`endif
      end
    end else if (key == m_held_key) m_held = 0;
    e.shift = m_lsh || m_rsh; e.held = m_held; e.cnt = CNT_W'(m_cnt); e.caps = m_caps;
    m_ext = 0; m_brk = 0;
    exp_q.push_back(e);
  endtask

  // ---------------- FIFO stand-in ----------------
  always @(negedge clk) begin
    if (!clrn && !kbd_nextdata_n && fifo.size() > 0) void'(fifo.pop_front());
    kbd_ready = (fifo.size() != 0);
    kbd_data  = kbd_ready ? fifo[0] : 8'h00;
  end

  // ---------------- monitor ----------------
  logic prev_valid = 1'b0, prev_nd = 1'b1;
  always @(negedge clk) begin
    if (clrn) begin
      prev_valid = 1'b0; prev_nd = 1'b1;
    end else begin
      if (!kbd_nextdata_n) begin
        n_lows++;
        chk("nextdata_single_cycle", prev_nd, 1'b1);
      end
      if (key_valid) begin
        chk("valid_single_cycle", prev_valid, 1'b0);
        if (exp_q.size() == 0) chk("unexpected_event", 1, 0);
        else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("key_code",    key_code,    e.code);
          chk("key_ext",     key_ext,     e.ext);
          chk("key_break",   key_break,   e.brk);
          chk("key_repeat",  key_repeat,  e.rep);
          chk("key_ascii",   key_ascii,   e.ascii);
          chk("shift_down",  shift_down,  e.shift);
          chk("key_held",    key_held,    e.held);
          chk("press_count", press_count, e.cnt);
`ifdef CAPS_LOCK_EN
          chk("caps_lock",   caps_lock,   e.caps);
`endif
        end
      end
      prev_valid = key_valid; prev_nd = kbd_nextdata_n;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b1;
    fifo.delete(); kbd_ready = 1'b0; kbd_data = 8'h00;
    exp_q.delete(); model_reset();
    repeat (2) @(negedge clk);
    n_lows = 0; n_sent = 0;
    clrn = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    fifo.push_back(b);
    n_sent++;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (fifo.size() != 0 && guard < 3000) begin @(negedge clk); guard++; end
    chk({tag, "_drain_timeout"}, guard < 3000, 1);
    repeat (6) @(negedge clk);
    chk({tag, "_pending_events"}, exp_q.size(), 0);
    chk({tag, "_pop_count"}, n_lows, n_sent);
  endtask

  task automatic send_list(input logic [7:0] bl[$]);
    foreach (bl[i]) send(bl[i]);
  endtask

  initial begin
    logic [7:0] keypool[12] = '{8'h1C,8'h32,8'h21,8'h12,8'h59,8'h58,8'h16,8'h45,8'h29,8'h5A,8'h66,8'h0E};
    logic [7:0] extpool[4]  = '{8'h75,8'h6B,8'h74,8'h1C};
    logic [7:0] noise[6]    = '{8'hAA,8'hFA,8'hEE,8'hFE,8'h00,8'hFF};
    int guard;
    build_map();
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_nextdata_n", kbd_nextdata_n, 1'b1);
    chk("rst_key_valid",  key_valid, 1'b0);
    chk("rst_key_code",   key_code, 8'h00);
    chk("rst_flags",      {key_ext, key_break, key_repeat, shift_down, key_held}, 5'b0);
    chk("rst_ascii",      key_ascii, 8'h00);
    chk("rst_count",      press_count, '0);
    clrn = 1'b0;

    send_list('{8'h1C, 8'hF0, 8'h1C}); drain("make_break");
    do_reset(); send_list('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12}); drain("shifted");
    do_reset(); send_list('{8'h1C, 8'h1C, 8'h1C}); drain("typematic");
    do_reset(); send_list('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75}); drain("extended");
    do_reset(); send_list('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29}); drain("pause");
    do_reset(); send_list('{8'hF0, 8'hE0, 8'h6B, 8'hE0, 8'hE0, 8'h6B, 8'hFA}); drain("prefix_order");

    // Reset lands during ACK of a latched F0; the prefix must be lost.
    do_reset();
    fifo.push_back(8'hF0);
    guard = 0;
    do begin @(posedge clk); #1; guard++; end while (kbd_nextdata_n && guard < 50);
    chk("midreset_pop_seen", guard < 50, 1);
    clrn = 1'b1;
    fifo.delete(); kbd_ready = 1'b0;
    #1 chk("midreset_nextdata_n", kbd_nextdata_n, 1'b1);
    @(negedge clk);
    exp_q.delete(); model_reset(); n_lows = 0; n_sent = 0;
    clrn = 1'b0;
    send(8'h1C); drain("midreset");

    do_reset();
    for (int round = 0; round < 12; round++) begin
      for (int ev = 0; ev < 25; ev++) begin
        int r = $urandom_range(0, 99);
        if (r < 5) begin
          send(8'hE1);
          for (int k = 0; k < PAUSE_SKIP; k++) send(8'($urandom_range(0, 255)));
        end else if (r < 12) begin
          send(noise[$urandom_range(0, 5)]);
        end else begin
          bit ext = ($urandom_range(0, 4) == 0);
          bit brk = ($urandom_range(0, 2) == 0);
          logic [7:0] code = ext ? extpool[$urandom_range(0, 3)] : keypool[$urandom_range(0, 11)];
          if (ext && brk && $urandom_range(0, 1) == 1) begin send(8'hF0); send(8'hE0); end
          else begin
            if (ext) send(8'hE0);
            if (brk) send(8'hF0);
          end
          send(code);
        end
      end
      drain("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
